// File: rtl/uart_cmd_parse_unit.sv
// uart_cmd_parse_unit
// Parses command frames from a byte stream (UART receiver side), issues a
// single write or read to the downstream register-access unit, and returns
// a response frame through a valid/ready byte transmitter.
//
// Optional feature: define CMD_CHECKSUM_EN to add an XOR checksum byte to
// both received and transmitted frames.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | hunting for HEADER, other bytes dropped
// CMD    | expecting command byte (01 write, 02 read)
// ADDR   | expecting address byte
// DATA   | collecting four write-data bytes, MSB first
// CSUM   | expecting checksum byte (only with CMD_CHECKSUM_EN)
// ISSUE  | waiting for downstream not-busy, then one-cycle enable
// WAIT   | waiting for downstream done pulse
// TX     | sending response bytes, one per accepted handshake

module uart_cmd_parse_unit #(
   parameter logic [7:0] HEADER         = 8'hA5,
   parameter int         TIMEOUT_CYCLES = 100000
) (
   input  logic        sys_clk,
   input  logic        reset_n,
   input  logic [7:0]  rx_data_in,
   input  logic        rx_valid_in,
   output logic [7:0]  tx_data_out,
   output logic        tx_valid_out,
   input  logic        tx_ready_in,
   output logic [7:0]  wr_addr_out,
   output logic [31:0] wr_data_out,
   output logic        wr_enable_out,
   input  logic        wr_done_in,
   input  logic        wr_busy_in,
   output logic [7:0]  rd_addr_out,
   output logic        rd_enable_out,
   input  logic [31:0] rd_data_in,
   input  logic        rd_done_in,
   input  logic        rd_busy_in,
   output logic        frame_err_out
);

   localparam int GAP_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(TIMEOUT_CYCLES - 1);

   localparam logic [7:0] CMD_WR = 8'h01;
   localparam logic [7:0] CMD_RD = 8'h02;
   localparam logic [7:0] RSP_WR = 8'h81;
   localparam logic [7:0] RSP_RD = 8'h82;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_DATA,
      ST_CSUM,
      ST_ISSUE,
      ST_WAIT,
      ST_TX
   } state_t;

`ifdef CMD_CHECKSUM_EN
   localparam state_t     ST_POST_RX = ST_CSUM;
   localparam logic [2:0] TX_LAST_WR = 3'd3;
   localparam logic [2:0] TX_LAST_RD = 3'd7;
`else
   localparam state_t     ST_POST_RX = ST_ISSUE;
   localparam logic [2:0] TX_LAST_WR = 3'd2;
   localparam logic [2:0] TX_LAST_RD = 3'd6;
`endif

   state_t            state_q;
   state_t            state_nxt;
   logic              err_set;
   logic              is_read_q;
   logic [7:0]        addr_q;
   logic [31:0]       data_q;
   logic [1:0]        byte_cnt_q;
   logic [GAP_W-1:0]  gap_cnt_q;
   logic [2:0]        tx_idx_q;
   logic              frame_err_q;
   logic [7:0]        tx_byte;

   logic              rx_phase;
   logic              timeout;
   logic              issue_go;
   logic              done_hit;
   logic              tx_fire;
   logic              tx_last;

`ifdef CMD_CHECKSUM_EN
   logic [7:0]        csum_q;
   logic [7:0]        rsp_csum;
`endif

   assign rx_phase = (state_q == ST_CMD)  || (state_q == ST_ADDR) ||
                     (state_q == ST_DATA) || (state_q == ST_CSUM);
   // Gap counter reaching zero on a strobe-less cycle is the terminal count.
   assign timeout  = rx_phase && !rx_valid_in && (gap_cnt_q == '0);
   assign issue_go = (state_q == ST_ISSUE) && (is_read_q ? !rd_busy_in : !wr_busy_in);
   assign done_hit = is_read_q ? rd_done_in : wr_done_in;
   assign tx_fire  = (state_q == ST_TX) && tx_ready_in;
   assign tx_last  = (tx_idx_q == (is_read_q ? TX_LAST_RD : TX_LAST_WR));

`ifdef CMD_CHECKSUM_EN
   assign rsp_csum = is_read_q ?
                     (RSP_RD ^ addr_q ^ data_q[31:24] ^ data_q[23:16] ^ data_q[15:8] ^ data_q[7:0]) :
                     (RSP_WR ^ addr_q);
`endif

   // State register.
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // Next-state decode and discarded-frame detection.
   always_comb begin
      state_nxt = state_q;
      err_set   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rx_valid_in && (rx_data_in == HEADER)) begin
               state_nxt = ST_CMD;
            end
         end
         ST_CMD: begin
            if (timeout) begin
               state_nxt = ST_IDLE;
               err_set   = 1'b1;
            end else if (rx_valid_in) begin
               // A repeated HEADER lands here as an unknown command.
               if ((rx_data_in == CMD_WR) || (rx_data_in == CMD_RD)) begin
                  state_nxt = ST_ADDR;
               end else begin
                  state_nxt = ST_IDLE;
                  err_set   = 1'b1;
               end
            end
         end
         ST_ADDR: begin
            if (timeout) begin
               state_nxt = ST_IDLE;
               err_set   = 1'b1;
            end else if (rx_valid_in) begin
               state_nxt = is_read_q ? ST_POST_RX : ST_DATA;
            end
         end
         ST_DATA: begin
            if (timeout) begin
               state_nxt = ST_IDLE;
               err_set   = 1'b1;
            end else if (rx_valid_in && (byte_cnt_q == 2'd3)) begin
               state_nxt = ST_POST_RX;
            end
         end
         ST_CSUM: begin
`ifdef CMD_CHECKSUM_EN
            if (timeout) begin
               state_nxt = ST_IDLE;
               err_set   = 1'b1;
            end else if (rx_valid_in) begin
               if (rx_data_in == csum_q) begin
                  state_nxt = ST_ISSUE;
               end else begin
                  state_nxt = ST_IDLE;
                  err_set   = 1'b1;
               end
            end
`else
            state_nxt = ST_IDLE;
`endif
         end
         ST_ISSUE: begin
            if (issue_go) begin
               state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (done_hit) begin
               state_nxt = ST_TX;
            end
         end
         ST_TX: begin
            if (tx_fire && tx_last) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Frame capture, inter-byte gap timer, read-data capture and tx index.
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         is_read_q   <= 1'b0;
         addr_q      <= 8'h00;
         data_q      <= 32'h0;
         byte_cnt_q  <= 2'd0;
         gap_cnt_q   <= GAP_RELOAD;
         tx_idx_q    <= 3'd0;
         frame_err_q <= 1'b0;
`ifdef CMD_CHECKSUM_EN
         csum_q      <= 8'h00;
`endif
      end else begin
         frame_err_q <= err_set;

         if (rx_phase && !rx_valid_in) begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
         end else begin
            gap_cnt_q <= GAP_RELOAD;
         end

         case (state_q)
            ST_IDLE: begin
               if (rx_valid_in && (rx_data_in == HEADER)) begin
                  data_q     <= 32'h0;
                  byte_cnt_q <= 2'd0;
               end
            end
            ST_CMD: begin
               if (rx_valid_in) begin
                  is_read_q <= (rx_data_in == CMD_RD);
`ifdef CMD_CHECKSUM_EN
                  csum_q    <= rx_data_in;
`endif
               end
            end
            ST_ADDR: begin
               if (rx_valid_in) begin
                  addr_q <= rx_data_in;
`ifdef CMD_CHECKSUM_EN
                  csum_q <= csum_q ^ rx_data_in;
`endif
               end
            end
            ST_DATA: begin
               if (rx_valid_in) begin
                  data_q     <= {data_q[23:0], rx_data_in};
                  byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef CMD_CHECKSUM_EN
                  csum_q     <= csum_q ^ rx_data_in;
`endif
               end
            end
            ST_WAIT: begin
               if (done_hit) begin
                  tx_idx_q <= 3'd0;
                  if (is_read_q) begin
                     data_q <= rd_data_in;
                  end
               end
            end
            ST_TX: begin
               if (tx_fire) begin
                  tx_idx_q <= tx_idx_q + 3'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Response byte selected by position in the outgoing frame.
   always_comb begin
      tx_byte = 8'h00;
      case (tx_idx_q)
         3'd0: tx_byte = HEADER;
         3'd1: tx_byte = is_read_q ? RSP_RD : RSP_WR;
         3'd2: tx_byte = addr_q;
`ifdef CMD_CHECKSUM_EN
         3'd3: tx_byte = is_read_q ? data_q[31:24] : rsp_csum;
`else
         3'd3: tx_byte = data_q[31:24];
`endif
         3'd4: tx_byte = data_q[23:16];
         3'd5: tx_byte = data_q[15:8];
         3'd6: tx_byte = data_q[7:0];
`ifdef CMD_CHECKSUM_EN
         3'd7: tx_byte = rsp_csum;
`endif
         default: tx_byte = 8'h00;
      endcase
   end

   assign tx_valid_out  = (state_q == ST_TX);
   assign tx_data_out   = tx_valid_out ? tx_byte : 8'h00;
   assign wr_addr_out   = addr_q;
   assign wr_data_out   = data_q;
   assign rd_addr_out   = addr_q;
   assign wr_enable_out = issue_go && !is_read_q;
   assign rd_enable_out = issue_go && is_read_q;
   assign frame_err_out = frame_err_q;

endmodule

// File: tb/tb_uart_cmd_parse_unit.sv
// Testbench for uart_cmd_parse_unit: directed and randomized command frames
// checked against a frame-level reference model (expected downstream command
// and expected response byte list built from the frame contents).

module tb_uart_cmd_parse_unit;

   localparam logic [7:0] HDR = 8'hA5;
   localparam int         TMO = 40;

   logic        sys_clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  rx_data_in = 8'h00;
   logic        rx_valid_in = 1'b0;
   logic [7:0]  tx_data_out;
   logic        tx_valid_out;
   logic        tx_ready_in = 1'b1;
   logic [7:0]  wr_addr_out;
   logic [31:0] wr_data_out;
   logic        wr_enable_out;
   logic        wr_done_in = 1'b0;
   logic        wr_busy_in = 1'b0;
   logic [7:0]  rd_addr_out;
   logic        rd_enable_out;
   logic [31:0] rd_data_in = 32'h0;
   logic        rd_done_in = 1'b0;
   logic        rd_busy_in = 1'b0;
   logic        frame_err_out;

   uart_cmd_parse_unit #(.HEADER(HDR), .TIMEOUT_CYCLES(TMO)) dut (
      .sys_clk       (sys_clk),
      .reset_n       (reset_n),
      .rx_data_in    (rx_data_in),
      .rx_valid_in   (rx_valid_in),
      .tx_data_out   (tx_data_out),
      .tx_valid_out  (tx_valid_out),
      .tx_ready_in   (tx_ready_in),
      .wr_addr_out   (wr_addr_out),
      .wr_data_out   (wr_data_out),
      .wr_enable_out (wr_enable_out),
      .wr_done_in    (wr_done_in),
      .wr_busy_in    (wr_busy_in),
      .rd_addr_out   (rd_addr_out),
      .rd_enable_out (rd_enable_out),
      .rd_data_in    (rd_data_in),
      .rd_done_in    (rd_done_in),
      .rd_busy_in    (rd_busy_in),
      .frame_err_out (frame_err_out)
   );

   always #5 sys_clk = ~sys_clk;

   int n_assert = 0;
   int n_fail   = 0;

   // observed-side bookkeeping, sampled mid-cycle
   int          wr_en_cnt = 0;
   int          rd_en_cnt = 0;
   int          err_cnt   = 0;
   int          stab_viol = 0;
   logic [7:0]  cap_wr_addr = 8'h00;
   logic [31:0] cap_wr_data = 32'h0;
   logic [7:0]  cap_rd_addr = 8'h00;
   logic        wr_fly = 1'b0;
   logic        rd_fly = 1'b0;
   logic        hold_pend = 1'b0;
   logic [7:0]  hold_byte = 8'h00;
   logic [7:0]  tx_q[$];

   // model-side: frame to send and response expected
   logic [7:0]  frm_q[$];
   logic [7:0]  exp_q[$];
   bit          rnd_ready = 1'b0;

   always @(negedge sys_clk) begin
      if (!reset_n) begin
         wr_fly    = 1'b0;
         rd_fly    = 1'b0;
         hold_pend = 1'b0;
      end else begin
         if (wr_enable_out) begin
            wr_en_cnt++;
            cap_wr_addr = wr_addr_out;
            cap_wr_data = wr_data_out;
            wr_fly      = 1'b1;
         end else if (wr_fly && (wr_addr_out !== cap_wr_addr || wr_data_out !== cap_wr_data)) begin
            stab_viol++;
         end
         if (wr_done_in) wr_fly = 1'b0;
         if (rd_enable_out) begin
            rd_en_cnt++;
            cap_rd_addr = rd_addr_out;
            rd_fly      = 1'b1;
         end else if (rd_fly && rd_addr_out !== cap_rd_addr) begin
            stab_viol++;
         end
         if (rd_done_in) rd_fly = 1'b0;
         if (frame_err_out) err_cnt++;
         if (tx_valid_out) begin
            if (hold_pend && tx_data_out !== hold_byte) stab_viol++;
            if (tx_ready_in) begin
               tx_q.push_back(tx_data_out);
               hold_pend = 1'b0;
            end else begin
               hold_pend = 1'b1;
               hold_byte = tx_data_out;
            end
         end else begin
            hold_pend = 1'b0;
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: observed no end of test, required finish within time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
      if (rnd_ready) tx_ready_in = 1'($urandom_range(0, 1));
   endtask

   function automatic logic [7:0] xor_tail(input logic [7:0] q[$]);
      logic [7:0] x;
      x = 8'h00;
      for (int i = 1; i < q.size(); i++) x = x ^ q[i];
      return x;
   endfunction

   task automatic build_write(input logic [7:0] a, input logic [31:0] d);
      frm_q.delete();
      exp_q.delete();
      frm_q.push_back(HDR);
      frm_q.push_back(8'h01);
      frm_q.push_back(a);
      for (int i = 3; i >= 0; i--) frm_q.push_back(d[i*8 +: 8]);
      exp_q.push_back(HDR);
      exp_q.push_back(8'h81);
      exp_q.push_back(a);
`ifdef CMD_CHECKSUM_EN
      frm_q.push_back(xor_tail(frm_q));
      exp_q.push_back(xor_tail(exp_q));
`endif
   endtask

   task automatic build_read(input logic [7:0] a, input logic [31:0] d);
      frm_q.delete();
      exp_q.delete();
      frm_q.push_back(HDR);
      frm_q.push_back(8'h02);
      frm_q.push_back(a);
      exp_q.push_back(HDR);
      exp_q.push_back(8'h82);
      exp_q.push_back(a);
      for (int i = 3; i >= 0; i--) exp_q.push_back(d[i*8 +: 8]);
`ifdef CMD_CHECKSUM_EN
      frm_q.push_back(xor_tail(frm_q));
      exp_q.push_back(xor_tail(exp_q));
`endif
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data_in  = b;
      rx_valid_in = 1'b1;
      tick();
      rx_valid_in = 1'b0;
      rx_data_in  = 8'($urandom);
   endtask

   task automatic send_frame(input int long_idx);
      for (int i = 0; i < frm_q.size(); i++) begin
         send_byte(frm_q[i]);
         if (i < frm_q.size() - 1) begin
            if (i == long_idx) repeat (TMO - 1) tick();
            else repeat ($urandom_range(0, 3)) tick();
         end
      end
   endtask

   task automatic send_noise();
      repeat ($urandom_range(2, 5)) begin
         send_byte(($urandom_range(0, 1) == 1) ? HDR : 8'($urandom));
      end
   endtask

   task automatic wait_tx(input string tag);
      int b;
      b = 0;
      while (tx_q.size() < exp_q.size() && b < 300) begin
         tick();
         b++;
      end
      repeat (4) tick();
      check({tag, "_tx_len"}, 64'(tx_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         check({tag, "_tx_byte"}, (i < tx_q.size()) ? 64'(tx_q[i]) : 64'hBAD, 64'(exp_q[i]));
      end
      check({tag, "_tx_idle"}, 64'(tx_valid_out), 64'(0));
   endtask

   task automatic run_write(input logic [7:0] a, input logic [31:0] d, input int busy,
                            input bit noise, input int long_idx);
      int w0, b;
      build_write(a, d);
      w0 = wr_en_cnt;
      tx_q.delete();
      wr_busy_in = (busy > 0);
      send_frame(long_idx);
      if (busy > 0) begin
         repeat (busy) tick();
         check("wr_en_held_by_busy", 64'(wr_en_cnt - w0), 64'(0));
         wr_busy_in = 1'b0;
      end
      b = 0;
      while (wr_en_cnt == w0 && b < 50) begin
         tick();
         b++;
      end
      if (noise) send_noise();
      repeat ($urandom_range(0, 4)) tick();
      check("wr_en_pulses", 64'(wr_en_cnt - w0), 64'(1));
      check("wr_addr", 64'(cap_wr_addr), 64'(a));
      check("wr_data", 64'(cap_wr_data), 64'(d));
      wr_done_in = 1'b1;
      tick();
      wr_done_in = 1'b0;
      wait_tx("wr");
   endtask

   task automatic run_read(input logic [7:0] a, input logic [31:0] d, input int busy,
                           input bit noise, input bit hold);
      int r0, b;
      build_read(a, d);
      r0 = rd_en_cnt;
      tx_q.delete();
      rd_busy_in = (busy > 0);
      send_frame(-1);
      if (busy > 0) begin
         repeat (busy) tick();
         check("rd_en_held_by_busy", 64'(rd_en_cnt - r0), 64'(0));
         rd_busy_in = 1'b0;
      end
      b = 0;
      while (rd_en_cnt == r0 && b < 50) begin
         tick();
         b++;
      end
      if (noise) send_noise();
      repeat ($urandom_range(0, 4)) tick();
      check("rd_en_pulses", 64'(rd_en_cnt - r0), 64'(1));
      check("rd_addr", 64'(cap_rd_addr), 64'(a));
      rd_data_in = d;
      rd_done_in = 1'b1;
      tick();
      rd_done_in = 1'b0;
      rd_data_in = $urandom;
      if (hold) begin
         b = 0;
         while (tx_q.size() < 3 && b < 50) begin
            tick();
            b++;
         end
         tx_ready_in = 1'b0;
         repeat (5) tick();
         check("tx_hold_count", 64'(tx_q.size()), 64'(3));
         check("tx_hold_valid", 64'(tx_valid_out), 64'(1));
         check("tx_hold_data", 64'(tx_data_out), 64'(exp_q[3]));
         tx_ready_in = 1'b1;
      end
      wait_tx("rd");
   endtask

   task automatic expect_err(input string tag);
      int e0, w0, r0;
      e0 = err_cnt;
      w0 = wr_en_cnt;
      r0 = rd_en_cnt;
      send_frame(-1);
      repeat (4) tick();
      check({tag, "_err"}, 64'(err_cnt - e0), 64'(1));
      check({tag, "_no_en"}, 64'((wr_en_cnt - w0) + (rd_en_cnt - r0)), 64'(0));
   endtask

   function automatic logic [7:0] rnd_addr();
      return 8'($urandom);
   endfunction

   initial begin
      int e0, w0, b;
      logic [7:0] nb;

      // reset state
      repeat (3) tick();
      check("reset_outputs", {tx_data_out, tx_valid_out, wr_addr_out, wr_data_out, wr_enable_out,
                              rd_addr_out, rd_enable_out, frame_err_out}, 64'(0));
      reset_n = 1'b1;

      // first strobe after release is honoured; canonical write
      run_write(8'h10, 32'h12345678, 0, 1'b0, -1);

      // canonical read with mid-frame backpressure
      run_read(8'h20, 32'hDEADBEEF, 0, 1'b0, 1'b1);

      // unknown command, then a normal read
      frm_q.delete();
      frm_q.push_back(HDR);
      frm_q.push_back(8'h03);
      expect_err("bad_cmd");
      run_read(rnd_addr(), $urandom, 0, 1'b0, 1'b0);

      // repeated HEADER is an invalid command
      frm_q.delete();
      frm_q.push_back(HDR);
      frm_q.push_back(HDR);
      expect_err("hdr_in_cmd");
      run_write(rnd_addr(), $urandom, 0, 1'b0, -1);

      // non-header bytes in IDLE are ignored silently
      e0 = err_cnt;
      w0 = wr_en_cnt + rd_en_cnt;
      for (int i = 0; i < 6; i++) begin
         nb = 8'($urandom);
         if (nb == HDR) nb = 8'h5A;
         send_byte(nb);
      end
      repeat (3) tick();
      check("idle_noise_err", 64'(err_cnt - e0), 64'(0));
      check("idle_noise_en", 64'(wr_en_cnt + rd_en_cnt - w0), 64'(0));
      run_write(rnd_addr(), $urandom, 0, 1'b0, -1);

      // inter-byte timeout: exactly TMO idle cycles in DATA
      e0 = err_cnt;
      w0 = wr_en_cnt;
      send_byte(HDR);
      send_byte(8'h01);
      send_byte(8'h10);
      send_byte(8'h12);
      repeat (TMO - 2) tick();
      check("timeout_not_early", 64'(err_cnt - e0), 64'(0));
      b = 0;
      while (err_cnt == e0 && b < 6) begin
         tick();
         b++;
      end
      check("timeout_err", 64'(err_cnt - e0), 64'(1));
      check("timeout_no_wr", 64'(wr_en_cnt - w0), 64'(0));
      run_read(rnd_addr(), $urandom, 0, 1'b0, 1'b0);

      // gap of TMO-1 idle cycles is still within budget
      run_write(rnd_addr(), $urandom, 0, 1'b0, 3);

      // downstream busy delays the enable
      run_write(rnd_addr(), $urandom, 10, 1'b0, -1);
      run_read(rnd_addr(), $urandom, 7, 1'b0, 1'b0);

      // strobes during WAIT are dropped
      run_write(rnd_addr(), $urandom, 0, 1'b1, -1);
      run_read(rnd_addr(), $urandom, 0, 1'b1, 1'b0);

`ifdef CMD_CHECKSUM_EN
      // wrong checksum on a read
      frm_q.delete();
      frm_q.push_back(HDR);
      frm_q.push_back(8'h02);
      frm_q.push_back(8'h20);
      frm_q.push_back(8'h00);
      expect_err("bad_csum");
`endif

      // randomized mix with random transmitter backpressure
      rnd_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if ($urandom_range(0, 1) == 1)
            run_write(rnd_addr(), $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)), -1);
         else
            run_read(rnd_addr(), $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
      end
      rnd_ready   = 1'b0;
      tx_ready_in = 1'b1;

      // reset during WAIT abandons the transaction
      build_write(8'h44, $urandom);
      w0 = wr_en_cnt;
      e0 = err_cnt;
      send_frame(-1);
      b = 0;
      while (wr_en_cnt == w0 && b < 50) begin
         tick();
         b++;
      end
      tick();
      reset_n = 1'b0;
      #1;
      check("reset_mid_wait_outputs", {tx_data_out, tx_valid_out, wr_addr_out, wr_data_out, wr_enable_out,
                                       rd_addr_out, rd_enable_out, frame_err_out}, 64'(0));
      tick();
      tick();
      reset_n = 1'b1;
      tx_q.delete();
      tick();
      wr_done_in = 1'b1;
      tick();
      wr_done_in = 1'b0;
      repeat (20) tick();
      check("stale_done_no_tx", 64'(tx_q.size()), 64'(0));
      check("stale_done_no_err", 64'(err_cnt - e0), 64'(0));
      run_read(rnd_addr(), $urandom, 0, 1'b0, 1'b0);

      check("stability_violations", 64'(stab_viol), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
